// File: rtl/ram_dp.sv
// True dual-port synchronous RAM with per-lane write enables, selectable
// same-port read-during-write behaviour and an optional output register stage.
module ram_dp #(
  parameter int    DEPTH     = 4,
  parameter int    WIDTH     = 8,
  parameter int    BYTE_W    = 8,
  parameter int    RD_MODE   = 1,
  parameter int    OUT_REG   = 0,
  parameter string INIT_FILE = "",
  localparam int   LANES     = WIDTH / BYTE_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_enable,
  input  logic [LANES-1:0] a_be,
  input  logic [DEPTH-1:0] a_address,
  input  logic [WIDTH-1:0] a_data_in,
  output logic [WIDTH-1:0] a_data_out,
  output logic             a_valid,
  input  logic             b_enable,
  input  logic [LANES-1:0] b_be,
  input  logic [DEPTH-1:0] b_address,
  input  logic [WIDTH-1:0] b_data_in,
  output logic [WIDTH-1:0] b_data_out,
  output logic             b_valid
);

  localparam int WORDS = 2 ** DEPTH;

  logic [WIDTH-1:0] r_mem [WORDS];

  function automatic logic [WIDTH-1:0] merge_lanes(
    input logic [WIDTH-1:0] base,
    input logic [WIDTH-1:0] data,
    input logic [LANES-1:0] mask
  );
    logic [WIDTH-1:0] word;
    word = base;
    for (int i = 0; i < LANES; i++) begin
      if (mask[i]) word[i*BYTE_W +: BYTE_W] = data[i*BYTE_W +: BYTE_W];
    end
    return word;
  endfunction

  logic             w_a_we, w_b_we;
  logic [LANES-1:0] w_a_mask, w_b_mask, w_a_mask_at_b, w_b_mask_at_a;
  logic [WIDTH-1:0] w_a_old, w_b_old, w_a_fin, w_b_fin;
  logic             w_a_rsp_vld, w_b_rsp_vld;
  logic [WIDTH-1:0] w_a_rsp_data, w_b_rsp_data;

  assign w_a_we   = a_enable && (a_be != '0) && !reset;
  assign w_b_we   = b_enable && (b_be != '0) && !reset;
  assign w_a_mask = w_a_we ? a_be : '0;
  assign w_b_mask = w_b_we ? b_be : '0;
  assign w_a_mask_at_b = (w_a_we && (a_address == b_address)) ? a_be : '0;
  assign w_b_mask_at_a = (w_b_we && (b_address == a_address)) ? b_be : '0;

  assign w_a_old = r_mem[a_address];
  assign w_b_old = r_mem[b_address];

  // Final stored word at each port's address: B lanes first, A overlays so A wins collisions.
  // On a same-address collision both expressions reduce to the same word.
  assign w_a_fin = merge_lanes(merge_lanes(w_a_old, b_data_in, w_b_mask_at_a), a_data_in, w_a_mask);
  assign w_b_fin = merge_lanes(merge_lanes(w_b_old, b_data_in, w_b_mask), a_data_in, w_a_mask_at_b);

  always_ff @(posedge clk) begin
    if (w_b_we) r_mem[b_address] <= w_b_fin;
    if (w_a_we) r_mem[a_address] <= w_a_fin;
  end

  always_comb begin
    w_a_rsp_vld  = 1'b0;
    w_a_rsp_data = w_a_old;
    if (a_enable) begin
      if (a_be == '0 || RD_MODE == 1) begin
        w_a_rsp_vld = 1'b1;
      end else if (RD_MODE == 2) begin
        w_a_rsp_vld  = 1'b1;
        w_a_rsp_data = w_a_fin;
      end
    end
  end

  always_comb begin
    w_b_rsp_vld  = 1'b0;
    w_b_rsp_data = w_b_old;
    if (b_enable) begin
      if (b_be == '0 || RD_MODE == 1) begin
        w_b_rsp_vld = 1'b1;
      end else if (RD_MODE == 2) begin
        w_b_rsp_vld  = 1'b1;
        w_b_rsp_data = w_b_fin;
      end
    end
  end

  // Stage 1: array read register; data holds when no response is produced
  logic [WIDTH-1:0] r_a_dout_p1, r_b_dout_p1;
  logic             r_a_vld_p1, r_b_vld_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_dout_p1 <= '0;
      r_b_dout_p1 <= '0;
      r_a_vld_p1  <= 1'b0;
      r_b_vld_p1  <= 1'b0;
    end else begin
      r_a_vld_p1 <= w_a_rsp_vld;
      r_b_vld_p1 <= w_b_rsp_vld;
      if (w_a_rsp_vld) r_a_dout_p1 <= w_a_rsp_data;
      if (w_b_rsp_vld) r_b_dout_p1 <= w_b_rsp_data;
    end
  end

  // Stage 2: optional output register, loaded only by a valid stage-1 word
  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [WIDTH-1:0] r_a_dout_p2, r_b_dout_p2;
      logic             r_a_vld_p2, r_b_vld_p2;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_a_dout_p2 <= '0;
          r_b_dout_p2 <= '0;
          r_a_vld_p2  <= 1'b0;
          r_b_vld_p2  <= 1'b0;
        end else begin
          r_a_vld_p2 <= r_a_vld_p1;
          r_b_vld_p2 <= r_b_vld_p1;
          if (r_a_vld_p1) r_a_dout_p2 <= r_a_dout_p1;
          if (r_b_vld_p1) r_b_dout_p2 <= r_b_dout_p1;
        end
      end

      assign a_data_out = r_a_dout_p2;
      assign a_valid    = r_a_vld_p2;
      assign b_data_out = r_b_dout_p2;
      assign b_valid    = r_b_vld_p2;
    end else begin : g_no_out_reg
      assign a_data_out = r_a_dout_p1;
      assign a_valid    = r_a_vld_p1;
      assign b_data_out = r_b_dout_p1;
      assign b_valid    = r_b_vld_p1;
    end
  endgenerate

endmodule

// File: tb/tb_ram_dp.sv
// Bench for ram_dp: four instances (NO_CHANGE, READ_FIRST, WRITE_FIRST, READ_FIRST+OUT_REG)
// share one stimulus stream and are compared to a word-level model plus fixed vectors.
module tb_ram_dp;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_en, b_en;
  logic [1:0]  a_be, b_be;
  logic [3:0]  a_addr, b_addr;
  logic [15:0] a_din, b_din;

  logic [15:0] dout [4][2];
  logic        vld  [4][2];

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    ram_dp #(
      .DEPTH(4), .WIDTH(16), .BYTE_W(8),
      .RD_MODE((g == 3) ? 1 : g), .OUT_REG((g == 3) ? 1 : 0), .INIT_FILE("")
    ) u_dut (
      .clk(clk), .reset(reset),
      .a_enable(a_en), .a_be(a_be), .a_address(a_addr), .a_data_in(a_din),
      .a_data_out(dout[g][0]), .a_valid(vld[g][0]),
      .b_enable(b_en), .b_be(b_be), .b_address(b_addr), .b_data_in(b_din),
      .b_data_out(dout[g][1]), .b_valid(vld[g][1])
    );
  end

  // Reference model: memory contents plus the visible output of each instance/port
  logic [15:0] m_mem [16];
  logic [15:0] m_out [4][2];
  logic        m_vld [4][2];
  logic [15:0] m_s1d [4][2];
  logic        m_s1v [4][2];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_step();
    logic [15:0] oldw [2];
    logic [15:0] finw [2];
    logic        en [2];
    logic [1:0]  be [2];
    logic [3:0]  ad [2];
    logic [15:0] dn [2];
    logic [15:0] rd;
    logic        rv;
    int          mode;
    en[0] = a_en; be[0] = a_be; ad[0] = a_addr; dn[0] = a_din;
    en[1] = b_en; be[1] = b_be; ad[1] = b_addr; dn[1] = b_din;
    if (reset) begin
      for (int k = 0; k < 4; k++)
        for (int p = 0; p < 2; p++) begin
          m_out[k][p] = '0; m_vld[k][p] = 1'b0;
          m_s1d[k][p] = '0; m_s1v[k][p] = 1'b0;
        end
      return;
    end
    for (int p = 0; p < 2; p++) oldw[p] = m_mem[ad[p]];
    // Apply B's write, then A's, so A's lanes win on a collision
    for (int p = 1; p >= 0; p--)
      if (en[p] && be[p] != 2'b00)
        for (int l = 0; l < 2; l++)
          if (be[p][l]) m_mem[ad[p]][l*8 +: 8] = dn[p][l*8 +: 8];
    for (int p = 0; p < 2; p++) finw[p] = m_mem[ad[p]];
    for (int k = 0; k < 4; k++) begin
      mode = (k == 3) ? 1 : k;
      for (int p = 0; p < 2; p++) begin
        rv = 1'b0; rd = '0;
        if (en[p]) begin
          if (be[p] == 2'b00) begin rv = 1'b1; rd = oldw[p]; end
          else if (mode == 1) begin rv = 1'b1; rd = oldw[p]; end
          else if (mode == 2) begin rv = 1'b1; rd = finw[p]; end
        end
        if (k == 3) begin
          if (m_s1v[k][p]) m_out[k][p] = m_s1d[k][p];
          m_vld[k][p] = m_s1v[k][p];
          if (rv) m_s1d[k][p] = rd;
          m_s1v[k][p] = rv;
        end else begin
          if (rv) m_out[k][p] = rd;
          m_vld[k][p] = rv;
        end
      end
    end
  endtask

  task automatic compare_model();
    for (int k = 0; k < 4; k++)
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("model dut%0d port%0d data", k, p), dout[k][p], m_out[k][p]);
        chk($sformatf("model dut%0d port%0d valid", k, p), 16'(vld[k][p]), 16'(m_vld[k][p]));
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_step();
    if (cmp_en) compare_model();
  endtask

  task automatic idle();
    a_en = 1'b0; a_be = 2'b00; b_en = 1'b0; b_be = 2'b00;
  endtask

  task automatic drive_a(input logic en, input logic [1:0] be, input logic [3:0] ad, input logic [15:0] dn);
    a_en = en; a_be = be; a_addr = ad; a_din = dn;
  endtask

  task automatic drive_b(input logic en, input logic [1:0] be, input logic [3:0] ad, input logic [15:0] dn);
    b_en = en; b_be = be; b_addr = ad; b_din = dn;
  endtask

  typedef struct packed {
    logic        a_en;
    logic [1:0]  a_be;
    logic [3:0]  a_addr;
    logic [15:0] a_din;
    logic        b_en;
    logic [1:0]  b_be;
    logic [3:0]  b_addr;
    logic [15:0] b_din;
    logic [15:0] ea;
    logic        eav;
    logic [15:0] eb;
    logic        ebv;
  } vec_t;

  vec_t vt [10];

  initial begin
    // Expected outputs are for the READ_FIRST, OUT_REG=0 instance
    vt[0] = '{1'b1, 2'b11, 4'd3, 16'hBEEF, 1'b0, 2'b00, 4'd0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0};
    vt[1] = '{1'b1, 2'b00, 4'd3, 16'h0000, 1'b0, 2'b00, 4'd0, 16'h0000, 16'hBEEF, 1'b1, 16'h0000, 1'b0};
    vt[2] = '{1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 2'b01, 4'd3, 16'h1234, 16'hBEEF, 1'b0, 16'hBEEF, 1'b1};
    vt[3] = '{1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 2'b00, 4'd3, 16'h0000, 16'hBEEF, 1'b0, 16'hBE34, 1'b1};
    vt[4] = '{1'b1, 2'b11, 4'd5, 16'hAAAA, 1'b1, 2'b00, 4'd5, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vt[5] = '{1'b1, 2'b00, 4'd5, 16'h0000, 1'b1, 2'b00, 4'd5, 16'h0000, 16'hAAAA, 1'b1, 16'hAAAA, 1'b1};
    vt[6] = '{1'b1, 2'b10, 4'd7, 16'h1111, 1'b1, 2'b11, 4'd7, 16'h2222, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vt[7] = '{1'b1, 2'b00, 4'd7, 16'h0000, 1'b0, 2'b00, 4'd0, 16'h0000, 16'h1122, 1'b1, 16'h0000, 1'b0};
    vt[8] = '{1'b1, 2'b00, 4'd3, 16'h0000, 1'b1, 2'b00, 4'd3, 16'h0000, 16'hBE34, 1'b1, 16'hBE34, 1'b1};
    vt[9] = '{1'b0, 2'b00, 4'd0, 16'h0000, 1'b0, 2'b00, 4'd0, 16'h0000, 16'hBE34, 1'b0, 16'hBE34, 1'b0};

    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    reset = 1'b1;
    idle();
    a_addr = '0; a_din = '0; b_addr = '0; b_din = '0;
    step();
    step();
    for (int k = 0; k < 4; k++)
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("reset dut%0d port%0d data", k, p), dout[k][p], 16'h0000);
        chk($sformatf("reset dut%0d port%0d valid", k, p), 16'(vld[k][p]), 16'h0000);
      end

    // Clear the array so contents are known; outputs settle after two reads
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive_a(1'b1, 2'b11, 4'(i), 16'h0000);
      drive_b(1'b1, 2'b11, 4'(i + 8), 16'h0000);
      step();
    end
    drive_a(1'b1, 2'b00, 4'd0, 16'h0000);
    drive_b(1'b1, 2'b00, 4'd0, 16'h0000);
    step();
    step();
    cmp_en = 1'b1;
    idle();
    step();

    for (int i = 0; i < 10; i++) begin
      drive_a(vt[i].a_en, vt[i].a_be, vt[i].a_addr, vt[i].a_din);
      drive_b(vt[i].b_en, vt[i].b_be, vt[i].b_addr, vt[i].b_din);
      step();
      chk($sformatf("vec%0d a_data", i), dout[1][0], vt[i].ea);
      chk($sformatf("vec%0d a_valid", i), 16'(vld[1][0]), 16'(vt[i].eav));
      chk($sformatf("vec%0d b_data", i), dout[1][1], vt[i].eb);
      chk($sformatf("vec%0d b_valid", i), 16'(vld[1][1]), 16'(vt[i].ebv));
      if (i == 4) begin
        chk("rdw no_change a_data", dout[0][0], 16'hBEEF);
        chk("rdw no_change a_valid", 16'(vld[0][0]), 16'h0000);
        chk("rdw write_first a_data", dout[2][0], 16'hAAAA);
        chk("rdw write_first a_valid", 16'(vld[2][0]), 16'h0001);
        chk("rdw cross no_change b_data", dout[0][1], 16'h0000);
        chk("rdw cross write_first b_data", dout[2][1], 16'h0000);
      end
      if (i == 6) begin
        chk("collision write_first a_data", dout[2][0], 16'h1122);
        chk("collision write_first b_data", dout[2][1], 16'h1122);
      end
    end

    // Output-register streaming on the OUT_REG=1 instance
    idle();
    drive_a(1'b1, 2'b11, 4'd0, 16'h0100); step();
    drive_a(1'b1, 2'b11, 4'd1, 16'h0111); step();
    drive_a(1'b1, 2'b11, 4'd2, 16'h0122); step();
    idle(); step(); step();
    drive_a(1'b1, 2'b00, 4'd0, 16'h0000); step();
    chk("oreg rd0 valid", 16'(vld[3][0]), 16'h0000);
    drive_a(1'b1, 2'b00, 4'd1, 16'h0000); step();
    chk("oreg word0 data", dout[3][0], 16'h0100);
    chk("oreg word0 valid", 16'(vld[3][0]), 16'h0001);
    drive_a(1'b1, 2'b00, 4'd2, 16'h0000); step();
    chk("oreg word1 data", dout[3][0], 16'h0111);
    chk("oreg word1 valid", 16'(vld[3][0]), 16'h0001);
    idle(); step();
    chk("oreg word2 data", dout[3][0], 16'h0122);
    chk("oreg word2 valid", 16'(vld[3][0]), 16'h0001);
    step();
    chk("oreg hold data", dout[3][0], 16'h0122);
    chk("oreg hold valid", 16'(vld[3][0]), 16'h0000);

    // Reset while a read is in flight, with a write presented during reset
    drive_a(1'b1, 2'b00, 4'd0, 16'h0000); step();
    reset = 1'b1;
    drive_a(1'b1, 2'b11, 4'd2, 16'hDEAD); step();
    chk("midreset oreg data", dout[3][0], 16'h0000);
    chk("midreset oreg valid", 16'(vld[3][0]), 16'h0000);
    chk("midreset rf data", dout[1][0], 16'h0000);
    reset = 1'b0;
    idle(); step();
    chk("postreset oreg valid", 16'(vld[3][0]), 16'h0000);
    chk("postreset oreg data", dout[3][0], 16'h0000);
    drive_a(1'b1, 2'b00, 4'd2, 16'h0000); step();
    chk("retained rf data", dout[1][0], 16'h0122);
    chk("retained rf valid", 16'(vld[1][0]), 16'h0001);
    idle(); step();
    chk("retained oreg data", dout[3][0], 16'h0122);
    chk("retained oreg valid", 16'(vld[3][0]), 16'h0001);

    // Randomised traffic, biased toward low addresses to provoke collisions
    for (int n = 0; n < 400; n++) begin
      reset  = ($urandom_range(0, 24) == 0);
      a_en   = ($urandom_range(0, 3) != 0);
      a_be   = 2'($urandom);
      a_addr = $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      a_din  = 16'($urandom);
      b_en   = ($urandom_range(0, 3) != 0);
      b_be   = 2'($urandom);
      b_addr = $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      b_din  = 16'($urandom);
      step();
    end
    reset = 1'b0;
    idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
